// File: rtl/reg_file_dumper.sv
// Walks register numbers 0..NUM_REGS-1 through a combinational register-file read port
// and presents each (number, value) pair on a valid/ready output stream.
module reg_file_dumper #(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rdNum,
  input  logic [31:0] rdData,
  output logic        outValid,
  input  logic        outReady,
  output logic [4:0]  outNum,
  output logic [31:0] outData,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  num_q, num_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    data_d  = data_q;
    // idx returns to 0 on every path into IDLE so rdNum reads 0 while idle
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = READ;
            idx_d   = '0;
          end
        end
        READ: begin
          num_d   = idx_q;
          data_d  = (idx_q == '0) ? '0 : rdData;
          state_d = SEND;
        end
        SEND: begin
          if (outReady) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = READ;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      data_q  <= data_d;
    end
  end

  // Status outputs decode the state register only, so none depend on outReady
  assign rdNum    = idx_q;
  assign outNum   = num_q;
  assign outData  = data_q;
  assign outValid = (state_q == SEND);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench for reg_file_dumper: full dumps, backpressure, ignored restart,
// abort, asynchronous reset, and a 4-register instance.
module tb_reg_file_dumper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, outReady;
  logic [4:0]  rdNum, outNum;
  logic [31:0] rdData, outData;
  logic        outValid, busy, done;

  logic        start4;
  logic [4:0]  rdNum4, outNum4;
  logic [31:0] rdData4, outData4;
  logic        outValid4, busy4, done4;

  logic [31:0] regs [32];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rdData  = regs[rdNum];
  assign rdData4 = regs[rdNum4];

  reg_file_dumper #(.NUM_REGS(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rdNum(rdNum), .rdData(rdData), .outValid(outValid), .outReady(outReady),
    .outNum(outNum), .outData(outData), .busy(busy), .done(done)
  );

  reg_file_dumper #(.NUM_REGS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(1'b0),
    .rdNum(rdNum4), .rdData(rdData4), .outValid(outValid4), .outReady(1'b1),
    .outNum(outNum4), .outData(outData4), .busy(busy4), .done(done4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int n);
    return (n == 0) ? 32'h0 : 32'h100 + 32'(n);
  endfunction

  // One complete dump with outReady high, optionally stalling one entry for
  // five cycles and/or pulsing start during one entry's SEND cycle.
  task automatic run_dump(input int stall_at, input int restart_at);
    int cyc;
    start = 1'b1; outReady = 1'b1;
    tick; start = 1'b0; cyc = 1;
    chk("busy_read", busy, 1);
    for (int n = 0; n < 32; n++) begin
      chk("rdnum_read", rdNum, n);
      chk("valid_in_read", outValid, 0);
      tick; cyc++;
      chk("valid_send", outValid, 1);
      chk("num_send", outNum, n);
      chk("data_send", outData, exp_data(n));
      if (n == stall_at) begin
        outReady = 1'b0;
        repeat (5) begin
          chk("stall_valid", outValid, 1);
          chk("stall_num", outNum, n);
          chk("stall_data", outData, exp_data(n));
          tick; cyc++;
        end
        outReady = 1'b1;
        chk("stall_release_num", outNum, n);
      end
      if (n == restart_at) start = 1'b1;
      if (n < 31) chk("done_early", done, 0);
      tick; cyc++;
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_cycle", cyc, 65 + ((stall_at >= 0) ? 5 : 0));
    tick;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", outValid, 0);
    chk("idle_rdnum", rdNum, 0);
    tick;
    chk("no_second_done", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
    regs[0] = 32'hDEADBEEF;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; outReady = 1'b0; start4 = 1'b0;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", outValid, 0);
    chk("rst_done", done, 0);
    chk("rst_rdnum", rdNum, 0);
    chk("rst_num", outNum, 0);
    chk("rst_data", outData, 0);
    tick; rst_n = 1'b1;
    tick;
    chk("idle_after_rst", busy, 0);

    run_dump(-1, -1);
    run_dump(3, -1);
    run_dump(-1, 10);

    // abort while entry 7 is stalled
    start = 1'b1; outReady = 1'b1;
    tick; start = 1'b0;
    for (int n = 0; n < 7; n++) begin
      tick; tick;
    end
    tick;
    chk("abort_pre_num", outNum, 7);
    chk("abort_pre_valid", outValid, 1);
    outReady = 1'b0; abort = 1'b1;
    tick; abort = 1'b0; outReady = 1'b1;
    chk("abort_valid", outValid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rdnum", rdNum, 0);
    tick; tick;
    chk("abort_no_done", done, 0);
    chk("abort_stay_idle", busy, 0);
    run_dump(-1, -1);

    // abort coinciding with a handshake still ends the dump
    start = 1'b1;
    tick; start = 1'b0;
    tick;
    chk("abort_hs_pre", outValid, 1);
    abort = 1'b1;
    tick; abort = 1'b0;
    chk("abort_hs_busy", busy, 0);
    chk("abort_hs_valid", outValid, 0);

    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    tick; start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", busy, 0);
    tick;
    chk("abort_start_idle2", busy, 0);

    // asynchronous reset in the middle of entry 20
    start = 1'b1;
    tick; start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick; tick;
    end
    tick;
    chk("mid_rst_pre_num", outNum, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", outValid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_num", outNum, 0);
    chk("mid_rst_data", outData, 0);
    chk("mid_rst_rdnum", rdNum, 0);
    chk("mid_rst_done", done, 0);
    tick; rst_n = 1'b1;
    tick; tick;
    chk("post_rst_valid", outValid, 0);
    chk("post_rst_busy", busy, 0);
    run_dump(-1, -1);

    // four-register instance
    begin
      int cyc;
      start4 = 1'b1;
      tick; start4 = 1'b0; cyc = 1;
      for (int n = 0; n < 4; n++) begin
        chk("n4_valid_read", outValid4, 0);
        tick; cyc++;
        chk("n4_valid", outValid4, 1);
        chk("n4_num", outNum4, n);
        chk("n4_data", outData4, exp_data(n));
        tick; cyc++;
      end
      chk("n4_done", done4, 1);
      chk("n4_done_cycle", cyc, 9);
      tick;
      chk("n4_done_one", done4, 0);
      chk("n4_idle", busy4, 0);
      chk("n4_no_wrap", outValid4, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
